// File: rtl/div16u8_seq_if.sv
// Valid/ready operand and result stream for the sequential 16/8 unsigned divider.
interface div16u8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf
    );
endinterface

// File: rtl/div16u8_seq.sv
// Restoring 16/8 unsigned divider, one quotient bit per cycle, MSB first.
// TRUNC_BITS low quotient bits are skipped to shorten latency (remainder then reads 0).
module div16u8_seq #(
    parameter int TRUNC_BITS = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    div16u8_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LP_K_LAST = 3'(TRUNC_BITS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_dvd_lo;
    logic [7:0] r_dsr;
    logic [7:0] r_rem;
    logic [7:0] r_q;
    logic [2:0] r_k;
    logic [7:0] r_quot;
    logic [7:0] r_rem_out;
    logic       r_ovf;

    logic       w_accept;
    logic       w_ovf_in;
    logic [8:0] w_t;
    logic       w_ge;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_q_nxt;
    logic       w_last;
    logic       w_in_ready;
    logic       w_out_valid;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    // Quotient would not fit in 8 bits (or divisor is zero): saturate without iterating.
    assign w_ovf_in = (bus.divisor == 8'd0) || (bus.dividend[15:8] >= bus.divisor);

    // One restoring step: R < divisor keeps the trial value within 9 bits.
    always_comb begin
        w_t       = {r_rem, r_dvd_lo[r_k]};
        w_ge      = (w_t >= {1'b0, r_dsr});
        w_rem_nxt = w_ge ? 8'(w_t - {1'b0, r_dsr}) : w_t[7:0];
        w_q_nxt   = r_q | ({7'd0, w_ge} << r_k);
        w_last    = (r_k == LP_K_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = w_ovf_in ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result load (results persist until next load).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd_lo  <= 8'd0;
            r_dsr     <= 8'd0;
            r_rem     <= 8'd0;
            r_q       <= 8'd0;
            r_k       <= 3'd0;
            r_quot    <= 8'd0;
            r_rem_out <= 8'd0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd_lo <= bus.dividend[7:0];
                        r_dsr    <= bus.divisor;
                        r_q      <= 8'd0;
                        r_k      <= 3'd7;
                        if (w_ovf_in) begin
                            r_rem     <= 8'd0;
                            r_quot    <= 8'hFF;
                            r_rem_out <= 8'd0;
                            r_ovf     <= 1'b1;
                        end else begin
                            r_rem <= bus.dividend[15:8];
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_k   <= r_k - 3'd1;
                    if (w_last) begin
                        r_quot    <= w_q_nxt;
                        r_rem_out <= (TRUNC_BITS == 0) ? w_rem_nxt : 8'd0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: begin
                    r_rem <= r_rem;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem_out;
    assign bus.ovf       = r_ovf;
endmodule
